idwt_synth_fir: RTL and testbench
=================================

// Module: idwt_synth_fir
// PURPOSE
//  Inverse-DWT synthesis stage: the reconstruction counterpart of the 4-tap analysis FIR (FIR_src).
//  - Accepts one (low, high) subband pair per transfer.
//  - Upsamples by 2 and filters through 4-tap synthesis filters g0 (low) and g1 (high).
//  - Emits two reconstructed samples per pair, even sample first.
//  - Sits after the subband buffers, at the output end of the DWT datapath.
// PARAMETERS
//  w_in   12  signed subband sample width (low and high)
//  c_in   5   signed coefficient width
//  y_out  20  signed output width; full precision = w_in+c_in+2
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous reset, active high
//  s_valid    in   1      input pair valid
//  s_ready    out  1      stage can accept a pair
//  s_sof      in   1      pair is first of a line/tile: history treated as zero
//  l_in       in   w_in   low subband sample l[m]
//  h_in       in   w_in   high subband sample h[m]
//  g0_0..g0_3 in   c_in   low synthesis coefficients (quasi-static)
//  g1_0..g1_3 in   c_in   high synthesis coefficients (quasi-static)
//  m_valid    out  1      y_k valid
//  m_ready    in   1      downstream accepts y_k
//  y_k        out  y_out  reconstructed sample
// BEHAVIOUR
//  - Polyphase equations (l1/h1 = previous accepted pair; 0 if s_sof):
//      even = g0_0*l + g0_2*l1 + g1_0*h + g1_2*h1
//      odd  = g0_1*l + g0_3*l1 + g1_1*h + g1_3*h1
//  - Arithmetic: signed products at w_in+c_in bits; sums at w_in+c_in+2 bits, no overflow.
//  - Accept = s_valid & s_ready. On the accept edge:
//    - even and odd are both computed and registered;
//    - l1/h1 are updated to l_in/h_in;
//    - coefficients are sampled at this edge.
//  - FSM:
//    - IDLE -> EVEN on accept.
//    - EVEN -> ODD on m_ready.
//    - ODD -> IDLE on m_ready & !accept.
//    - ODD -> EVEN on m_ready & accept (back-to-back pairs).
//  - Outputs by state:
//    - m_valid = (state != IDLE).
//    - y_k = even register in EVEN, odd register in ODD.
//    - s_ready = (state==IDLE) | (state==ODD & m_ready).
//  - Timing: latency accept edge -> m_valid high is 1 cycle. Peak throughput is 1 pair per 2 cycles.
//  - Backpressure: m_ready low holds y_k, m_valid and state unchanged; no sample is dropped or reordered.
//  - s_valid may drop without a transfer; an unaccepted pair has no effect on state or history.
//  - Reset (any time, including mid-pair):
//    - state=IDLE, m_valid=0, y_k=0, s_ready=1 (combinational, follows IDLE);
//    - l1=h1=0, even/odd registers=0;
//    - a pending odd sample is discarded.
//  - Output width:
//    - y_out >= full precision: sign-extended.
//    - y_out < full precision: see CONFIGURATION.
// CONFIGURATION
//  IDWT_SAT_EN defined:
//    - If y_out < full precision, each sum saturates to [-2^(y_out-1), 2^(y_out-1)-1] before registering.
//  IDWT_SAT_EN undefined:
//    - Low y_out bits are kept (two's-complement wrap).
//  No effect when y_out >= full precision.
// TESTING
//  1 Reset: rst=1 mid-stream -> next cycle m_valid=0, y_k=0; after release s_ready=1.
//  2 Haar: g0=(1,1,0,0), g1=(1,-1,0,0), sof pair l=5,h=3 -> y_k=8 then 2, m_valid 1 cycle after accept.
//  3 History: g0=(1,2,3,4), g1=0, h=0; pair l=1 (sof) -> 1,2; pair l=2 -> 5,8; pair l=7 with sof -> 7,14.
//  4 Backpressure: random m_ready, s_valid held high over 16 pairs -> output equals reference model, order preserved, s_ready=0 while EVEN.
//  5 Width, y_out=8, l=2047, g0_0=15, other coefficients 0, h=0:
//      with IDWT_SAT_EN -> even=127;
//      without -> even=-15 (30705 mod 256).
//  6 Reset in EVEN, then non-sof pair l=4 with g0=(1,1,1,1) -> 4,4 (history cleared).

Source files
------------

// File: rtl/idwt_synth_fir_if.sv
// Streaming bus for idwt_synth_fir: (low, high) subband pair in, reconstructed samples out.
interface idwt_synth_fir_if #(
   parameter int unsigned w_in  = 12,
   parameter int unsigned y_out = 20
);
   logic                    s_valid;
   logic                    s_ready;
   logic                    s_sof;
   logic signed [w_in-1:0]  l_in;
   logic signed [w_in-1:0]  h_in;
   logic                    m_valid;
   logic                    m_ready;
   logic signed [y_out-1:0] y_k;

   modport master (
      output s_valid, s_sof, l_in, h_in, m_ready,
      input  s_ready, m_valid, y_k
   );

   modport slave (
      input  s_valid, s_sof, l_in, h_in, m_ready,
      output s_ready, m_valid, y_k
   );
endinterface

// File: rtl/idwt_synth_fir.sv
// Inverse-DWT synthesis stage: 4-tap polyphase reconstruction, two output samples per pair.
// Define IDWT_SAT_EN to saturate (instead of wrap) when y_out is narrower than full precision.
module idwt_synth_fir #(
   parameter int unsigned w_in  = 12,
   parameter int unsigned c_in  = 5,
   parameter int unsigned y_out = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   idwt_synth_fir_if.slave        bus,
   input  logic signed [c_in-1:0] g0_0,
   input  logic signed [c_in-1:0] g0_1,
   input  logic signed [c_in-1:0] g0_2,
   input  logic signed [c_in-1:0] g0_3,
   input  logic signed [c_in-1:0] g1_0,
   input  logic signed [c_in-1:0] g1_1,
   input  logic signed [c_in-1:0] g1_2,
   input  logic signed [c_in-1:0] g1_3
);
   localparam int unsigned p_w  = w_in + c_in;
   localparam int unsigned full = p_w + 2;

   typedef enum logic [1:0] {StIdle, StEven, StOdd} state_e;

   state_e                  state_q, state_d;
   logic                    accept;
   logic signed [w_in-1:0]  l1_q, h1_q, l1, h1;
   logic signed [full-1:0]  sum [2];
   logic signed [y_out-1:0] fit [2];
   logic signed [y_out-1:0] even_q, odd_q;

   function automatic logic signed [full-1:0] mac(input logic signed [w_in-1:0] a,
                                                  input logic signed [c_in-1:0] b);
      logic signed [p_w-1:0] ax, bx, p;
      ax = {{c_in{a[w_in-1]}}, a};
      bx = {{w_in{b[c_in-1]}}, b};
      p  = ax * bx;
      return {{2{p[p_w-1]}}, p};
   endfunction

   // A start-of-line pair sees zero history regardless of the stored pair.
   assign l1 = bus.s_sof ? '0 : l1_q;
   assign h1 = bus.s_sof ? '0 : h1_q;

   assign sum[0] = mac(bus.l_in, g0_0) + mac(l1, g0_2) + mac(bus.h_in, g1_0) + mac(h1, g1_2);
   assign sum[1] = mac(bus.l_in, g0_1) + mac(l1, g0_3) + mac(bus.h_in, g1_1) + mac(h1, g1_3);

   for (genvar i = 0; i < 2; i++) begin : g_fit
      if (y_out > full) begin : g_ext
         assign fit[i] = {{(y_out-full){sum[i][full-1]}}, sum[i]};
      end else if (y_out == full) begin : g_same
         assign fit[i] = sum[i];
      end else begin : g_narrow
`ifdef IDWT_SAT_EN
         localparam logic signed [full-1:0] sat_max =
            {{(full-y_out+1){1'b0}}, {(y_out-1){1'b1}}};
         localparam logic signed [full-1:0] sat_min =
            {{(full-y_out+1){1'b1}}, {(y_out-1){1'b0}}};
         assign fit[i] = (sum[i] > sat_max) ? sat_max[y_out-1:0] :
                         (sum[i] < sat_min) ? sat_min[y_out-1:0] : sum[i][y_out-1:0];
`else
         assign fit[i] = sum[i][y_out-1:0];
`endif
      end
   end

   assign bus.s_ready = (state_q == StIdle) || ((state_q == StOdd) && bus.m_ready);
   assign accept      = bus.s_valid && bus.s_ready;
   assign bus.m_valid = (state_q != StIdle);
   assign bus.y_k     = (state_q == StEven) ? even_q :
                        (state_q == StOdd)  ? odd_q  : '0;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StEven;
         StEven:  if (bus.m_ready) state_d = StOdd;
         StOdd:   if (bus.m_ready) state_d = accept ? StEven : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         l1_q    <= '0;
         h1_q    <= '0;
         even_q  <= '0;
         odd_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            l1_q   <= bus.l_in;
            h1_q   <= bus.h_in;
            even_q <= fit[0];
            odd_q  <= fit[1];
         end
      end
   end
endmodule

// File: tb/tb_idwt_synth_fir.sv
// Self-checking bench for idwt_synth_fir: directed cases plus randomized backpressure
// against a polyphase reference model; a y_out=8 instance covers the narrow-output path.
module tb_idwt_synth_fir;
   logic clk = 1'b0;
   logic rst;
   logic signed [4:0] c0 [4];
   logic signed [4:0] c1 [4];

   idwt_synth_fir_if #(.w_in(12), .y_out(20)) bus ();
   idwt_synth_fir_if #(.w_in(12), .y_out(8))  bus8 ();

   idwt_synth_fir #(.w_in(12), .c_in(5), .y_out(20)) u_dut (
      .clk(clk), .rst(rst), .bus(bus),
      .g0_0(c0[0]), .g0_1(c0[1]), .g0_2(c0[2]), .g0_3(c0[3]),
      .g1_0(c1[0]), .g1_1(c1[1]), .g1_2(c1[2]), .g1_3(c1[3])
   );

   idwt_synth_fir #(.w_in(12), .c_in(5), .y_out(8)) u_dut8 (
      .clk(clk), .rst(rst), .bus(bus8),
      .g0_0(c0[0]), .g0_1(c0[1]), .g0_2(c0[2]), .g0_3(c0[3]),
      .g1_0(c1[0]), .g1_1(c1[1]), .g1_2(c1[2]), .g1_3(c1[3])
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int l1m = 0;
   int h1m = 0;
   int exp_q[$];

   task automatic check(input string tag, input logic signed [31:0] obs, input int expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference model: spec polyphase equations in plain integer arithmetic.
   task automatic model_push(input bit sof, input int l, input int h);
      int lp, hp;
      lp = sof ? 0 : l1m;
      hp = sof ? 0 : h1m;
      exp_q.push_back(int'(c0[0]) * l + int'(c0[2]) * lp + int'(c1[0]) * h + int'(c1[2]) * hp);
      exp_q.push_back(int'(c0[1]) * l + int'(c0[3]) * lp + int'(c1[1]) * h + int'(c1[3]) * hp);
      l1m = l;
      h1m = h;
   endtask

   function automatic int fit8(input int v);
`ifdef IDWT_SAT_EN
      return (v > 127) ? 127 : (v < -128) ? -128 : v;
`else
      int m;
      m = ((v % 256) + 256) % 256;
      return (m > 127) ? m - 256 : m;
`endif
   endfunction

   task automatic set_coef(input int a0, a1, a2, a3, b0, b1, b2, b3);
      c0[0] = 5'(a0); c0[1] = 5'(a1); c0[2] = 5'(a2); c0[3] = 5'(a3);
      c1[0] = 5'(b0); c1[1] = 5'(b1); c1[2] = 5'(b2); c1[3] = 5'(b3);
   endtask

   // One clock: drive at negedge, check outputs against the model, update model at posedge.
   task automatic cyc(input bit sv, input bit sof, input int l, input int h, input bit mr,
                      output bit acc);
      bit xfer, rdy;
      @(negedge clk);
      bus.s_valid = sv;
      bus.s_sof   = sof;
      bus.l_in    = 12'(l);
      bus.h_in    = 12'(h);
      bus.m_ready = mr;
      #1;
      rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && mr);
      check("m_valid", bus.m_valid, int'(exp_q.size() != 0));
      check("s_ready", bus.s_ready, int'(rdy));
      if (exp_q.size() != 0) check("y_k", bus.y_k, exp_q[0]);
      xfer = (exp_q.size() != 0) && mr;
      acc  = sv && rdy;
      @(posedge clk);
      if (xfer) void'(exp_q.pop_front());
      if (acc) model_push(sof, l, h);
   endtask

   task automatic send(input bit sof, input int l, input int h);
      bit acc;
      acc = 1'b0;
      for (int b = 0; b < 20 && !acc; b++) cyc(1'b1, sof, l, h, 1'b1, acc);
   endtask

   task automatic drain();
      bit acc;
      for (int b = 0; b < 50 && exp_q.size() != 0; b++) cyc(1'b0, 1'b0, 0, 0, 1'b1, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      bus.s_valid  = 1'b0;
      bus8.s_valid = 1'b0;
      #1;
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_y_k", bus.y_k, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      l1m = 0;
      h1m = 0;
      #1;
      check("rst_s_ready", bus.s_ready, 1);
      check("rst_m_valid_after", bus.m_valid, 0);
   endtask

   initial begin
      bit acc, sof;
      int n, l, h;
      rst = 1'b1;
      bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.l_in = '0; bus.h_in = '0; bus.m_ready = 1'b1;
      bus8.s_valid = 1'b0; bus8.s_sof = 1'b0; bus8.l_in = '0; bus8.h_in = '0;
      bus8.m_ready = 1'b1;
      set_coef(0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();

      // Reset mid-stream with an odd sample pending.
      set_coef(3, -2, 5, 1, 2, 7, -4, 1);
      send(1'b1, 100, -50);
      cyc(1'b0, 1'b0, 0, 0, 1'b1, acc);
      do_reset();

      // Haar pair.
      set_coef(1, 1, 0, 0, 1, -1, 0, 0);
      send(1'b1, 5, 3);
      #1;
      check("haar_valid_latency", bus.m_valid, 1);
      check("haar_even", bus.y_k, 8);
      cyc(1'b0, 1'b0, 0, 0, 1'b1, acc);
      #1;
      check("haar_odd", bus.y_k, 2);
      drain();

      // History across pairs and sof clearing.
      set_coef(1, 2, 3, 4, 0, 0, 0, 0);
      send(1'b1, 1, 0);
      #1 check("hist_even0", bus.y_k, 1);
      send(1'b0, 2, 0);
      #1 check("hist_even1", bus.y_k, 5);
      send(1'b1, 7, 0);
      #1 check("hist_even2", bus.y_k, 7);
      drain();

      // Random data and backpressure, s_valid held until accepted.
      for (int k = 0; k < 4; k++) begin
         c0[k] = 5'($urandom_range(0, 31));
         c1[k] = 5'($urandom_range(0, 31));
      end
      n = 0;
      sof = 1'b1;
      l = int'($urandom_range(0, 4095)) - 2048;
      h = int'($urandom_range(0, 4095)) - 2048;
      for (int b = 0; b < 400 && n < 16; b++) begin
         cyc(1'b1, sof, l, h, 1'($urandom_range(0, 1)), acc);
         if (acc) begin
            n++;
            sof = ($urandom_range(0, 4) == 0);
            l = int'($urandom_range(0, 4095)) - 2048;
            h = int'($urandom_range(0, 4095)) - 2048;
         end
      end
      drain();

      // Reset while in EVEN clears history.
      set_coef(2, 3, -5, 6, 1, 1, 4, -3);
      send(1'b0, 9, 9);
      do_reset();
      set_coef(1, 1, 1, 1, 0, 0, 0, 0);
      send(1'b0, 4, 0);
      #1 check("post_rst_even", bus.y_k, 4);
      drain();

      // Narrow output width on the y_out=8 instance.
      set_coef(15, 0, 0, 0, 0, 0, 0, 0);
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         l = (s == 0) ? 2047 : -2048;
         bus8.s_valid = 1'b1; bus8.s_sof = 1'b1;
         bus8.l_in = 12'(l); bus8.h_in = '0; bus8.m_ready = 1'b1;
         @(posedge clk);
         #1;
         bus8.s_valid = 1'b0;
         check("w8_valid", bus8.m_valid, 1);
         check("w8_even", bus8.y_k, fit8(15 * l));
         @(posedge clk);
         #1 check("w8_odd", bus8.y_k, 0);
         @(posedge clk);
         #1 check("w8_idle", bus8.m_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
